// File: rtl/cmd_proc.sv
// Command sequencer sitting in front of navigation. Decodes 16-bit link
// commands into start strobes, heading and stop qualifiers, waits for the
// matching completion pulse and answers with a one-byte ACK/NAK response.
// Every output comes straight from a flop.
module cmd_proc #(
  parameter logic [7:0] ACK = 8'hA5,
  parameter logic [7:0] NAK = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        strt_cal,
  input  logic        cal_done,
  output logic        strt_hdng,
  output logic        strt_mv,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic [11:0] dsrd_hdng,
  input  logic        mv_cmplt,
  output logic        cmd_md,
  output logic        strt_solve,
  output logic        lft_aff,
  input  logic        sol_cmplt,
  output logic        send_resp,
  output logic [7:0]  resp
);

  typedef enum logic [2:0] {IDLE, CAL, HDNG, MOVE, SOLVE, RESP} state_t;

  state_t      state_q;
  // High during the first cycle of a wait state: the start action fires then
  // and completion inputs are not yet looked at.
  logic        first_q;
  // Operand bits captured when the command is consumed; the link may change
  // cmd as soon as clr_cmd_rdy has been seen.
  logic [11:0] fld_q;

  logic        clr_cmd_rdy_q, strt_cal_q, strt_hdng_q, strt_mv_q;
  logic        strt_solve_q, send_resp_q;
  logic        stp_lft_q, stp_rght_q, cmd_md_q, lft_aff_q;
  logic [11:0] dsrd_hdng_q;
  logic [7:0]  resp_q;

  // Bit 12 carries no meaning for any opcode.
  logic        unused_cmd_bit;
  assign unused_cmd_bit = cmd[12];

  // Sequencer FSM: decode, start action, completion wait and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      first_q       <= 1'b0;
      fld_q         <= 12'h000;
      clr_cmd_rdy_q <= 1'b0;
      strt_cal_q    <= 1'b0;
      strt_hdng_q   <= 1'b0;
      strt_mv_q     <= 1'b0;
      strt_solve_q  <= 1'b0;
      send_resp_q   <= 1'b0;
      stp_lft_q     <= 1'b0;
      stp_rght_q    <= 1'b0;
      cmd_md_q      <= 1'b1;
      lft_aff_q     <= 1'b0;
      dsrd_hdng_q   <= 12'h000;
      resp_q        <= 8'h00;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      clr_cmd_rdy_q <= 1'b0;
      strt_cal_q    <= 1'b0;
      strt_hdng_q   <= 1'b0;
      strt_mv_q     <= 1'b0;
      strt_solve_q  <= 1'b0;
      send_resp_q   <= 1'b0;
      first_q       <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cmd_rdy) begin
            clr_cmd_rdy_q <= 1'b1;
            fld_q         <= cmd[11:0];
            first_q       <= 1'b1;
            case (cmd[15:13])
              3'b000:  state_q <= CAL;
              3'b001:  state_q <= HDNG;
              3'b010:  state_q <= MOVE;
              3'b011:  state_q <= SOLVE;
              default: begin
                state_q <= RESP;
                resp_q  <= NAK;
              end
            endcase
          end
        end

        CAL: begin
          if (first_q) begin
            strt_cal_q <= 1'b1;
          end else if (cal_done) begin
            state_q <= RESP;
            resp_q  <= ACK;
          end
        end

        HDNG: begin
          if (first_q) begin
            strt_hdng_q <= 1'b1;
            dsrd_hdng_q <= fld_q;
          end else if (mv_cmplt) begin
            state_q <= RESP;
            resp_q  <= ACK;
          end
        end

        MOVE: begin
          if (first_q) begin
            strt_mv_q  <= 1'b1;
            stp_lft_q  <= fld_q[1];
            stp_rght_q <= fld_q[0];
          end else if (mv_cmplt) begin
            stp_lft_q  <= 1'b0;
            stp_rght_q <= 1'b0;
            state_q    <= RESP;
            resp_q     <= ACK;
          end
        end

        SOLVE: begin
          if (first_q) begin
            strt_solve_q <= 1'b1;
            cmd_md_q     <= 1'b0;
            lft_aff_q    <= fld_q[0];
          end else if (sol_cmplt) begin
            cmd_md_q <= 1'b1;
            state_q  <= RESP;
            resp_q   <= ACK;
          end
        end

        RESP: begin
          send_resp_q <= 1'b1;
          state_q     <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign clr_cmd_rdy = clr_cmd_rdy_q;
  assign strt_cal    = strt_cal_q;
  assign strt_hdng   = strt_hdng_q;
  assign strt_mv     = strt_mv_q;
  assign strt_solve  = strt_solve_q;
  assign send_resp   = send_resp_q;
  assign stp_lft     = stp_lft_q;
  assign stp_rght    = stp_rght_q;
  assign cmd_md      = cmd_md_q;
  assign lft_aff     = lft_aff_q;
  assign dsrd_hdng   = dsrd_hdng_q;
  assign resp        = resp_q;

endmodule

// File: tb/tb_cmd_proc.sv
// Bench for cmd_proc: directed scenarios followed by randomized command
// streams, checked against a transaction-level model of the command rules.
module tb_cmd_proc;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'h5A;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        cmd_rdy, cal_done, mv_cmplt, sol_cmplt;
  logic        clr_cmd_rdy, strt_cal, strt_hdng, strt_mv, strt_solve;
  logic        stp_lft, stp_rght, cmd_md, lft_aff, send_resp;
  logic [11:0] dsrd_hdng;
  logic [7:0]  resp;

  int checks   = 0;
  int failures = 0;

  // Model state: what the outputs that persist across commands should hold.
  logic [11:0] m_hdng;
  logic [7:0]  m_resp;
  logic        m_aff;

  cmd_proc #(.ACK(ACK), .NAK(NAK)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .strt_cal(strt_cal), .cal_done(cal_done),
    .strt_hdng(strt_hdng), .strt_mv(strt_mv), .stp_lft(stp_lft),
    .stp_rght(stp_rght), .dsrd_hdng(dsrd_hdng), .mv_cmplt(mv_cmplt),
    .cmd_md(cmd_md), .strt_solve(strt_solve), .lft_aff(lft_aff),
    .sol_cmplt(sol_cmplt), .send_resp(send_resp), .resp(resp)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_strobes"}, {clr_cmd_rdy, strt_cal, strt_hdng, strt_mv, strt_solve, send_resp}, 0);
    check_val({tag, "_levels"}, {stp_lft, stp_rght, lft_aff, cmd_md}, 4'b0001);
    check_val({tag, "_hdng"}, dsrd_hdng, 12'h000);
    check_val({tag, "_resp"}, resp, 8'h00);
  endtask

  // One command from acceptance to response. Entry: at a negedge with the
  // DUT idle. Exit: at the negedge of the cycle in which send_resp is high.
  task automatic run_cmd(input logic [15:0] w, input int d, input bit preloaded,
                         input bit stray, input bit pre_next, input logic [15:0] nxt);
    logic [2:0] op;
    logic       exp_l, exp_r, exp_md;
    op = w[15:13];
    if (!preloaded) begin
      cmd     = w;
      cmd_rdy = 1'b1;
    end
    step();
    check_val("accept_clr", clr_cmd_rdy, 1);
    check_val("accept_quiet", {strt_cal, strt_hdng, strt_mv, strt_solve, send_resp}, 0);
    cmd_rdy = 1'b0;
    cmd     = 16'($urandom);
    step();
    if (op >= 3'd4) begin
      check_val("nak_send", send_resp, 1);
      check_val("nak_resp", resp, NAK);
      check_val("nak_nostrobe", {strt_cal, strt_hdng, strt_mv, strt_solve, clr_cmd_rdy}, 0);
      check_val("nak_hdng", dsrd_hdng, m_hdng);
      m_resp = NAK;
      if (pre_next) begin
        cmd     = nxt;
        cmd_rdy = 1'b1;
      end
      return;
    end
    if (op == 3'd1) m_hdng = w[11:0];
    if (op == 3'd3) m_aff = w[0];
    exp_l  = (op == 3'd2) && w[1];
    exp_r  = (op == 3'd2) && w[0];
    exp_md = (op != 3'd3);
    check_val("start_strobes", {strt_cal, strt_hdng, strt_mv, strt_solve},
              {op == 3'd0, op == 3'd1, op == 3'd2, op == 3'd3});
    check_val("start_noresp", {send_resp, clr_cmd_rdy}, 0);
    check_val("start_hdng", dsrd_hdng, m_hdng);
    check_val("start_stp", {stp_lft, stp_rght}, {exp_l, exp_r});
    check_val("start_md_aff", {cmd_md, lft_aff}, {exp_md, m_aff});
    if (pre_next) begin
      cmd     = nxt;
      cmd_rdy = 1'b1;
    end
    for (int i = 0; i < d; i++) begin
      if (stray && (i % 2 == 0)) begin
        cal_done  = (op != 3'd0);
        mv_cmplt  = (op == 3'd0) || (op == 3'd3);
        sol_cmplt = (op != 3'd3);
      end
      step();
      cal_done = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
      check_val("wait_quiet", {send_resp, clr_cmd_rdy, strt_cal, strt_hdng, strt_mv, strt_solve}, 0);
      check_val("wait_levels", {stp_lft, stp_rght, cmd_md, lft_aff}, {exp_l, exp_r, exp_md, m_aff});
    end
    case (op)
      3'd0:    cal_done  = 1'b1;
      3'd3:    sol_cmplt = 1'b1;
      default: mv_cmplt  = 1'b1;
    endcase
    step();
    cal_done = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    check_val("done_nosend", {send_resp, clr_cmd_rdy}, 0);
    check_val("done_levels", {stp_lft, stp_rght, cmd_md}, 3'b001);
    step();
    check_val("resp_send", send_resp, 1);
    check_val("resp_ack", resp, ACK);
    check_val("resp_quiet", {clr_cmd_rdy, strt_cal, strt_hdng, strt_mv, strt_solve}, 0);
    check_val("resp_hdng", dsrd_hdng, m_hdng);
    m_resp = ACK;
  endtask

  // Accept w, let its start strobe fire, then hit reset.
  task automatic reset_mid(input logic [15:0] w);
    cmd = w; cmd_rdy = 1'b1;
    step();
    check_val("rstmid_clr", clr_cmd_rdy, 1);
    cmd_rdy = 1'b0;
    step();
    check_val("rstmid_strobe", {strt_cal, strt_mv, strt_solve},
              {w[15:13] == 3'd0, w[15:13] == 3'd2, w[15:13] == 3'd3});
    rst = 1'b1;
    step();
    check_reset_vals("rstmid");
    rst = 1'b0;
    m_hdng = 12'h000; m_resp = 8'h00; m_aff = 1'b0;
    cal_done = 1'b1; mv_cmplt = 1'b1; sol_cmplt = 1'b1;
    step();
    cal_done = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("rstmid_nosend", {send_resp, clr_cmd_rdy}, 0);
      check_val("rstmid_resp", resp, 8'h00);
    end
  endtask

  initial begin
    logic [15:0] cur_w, nxt_w;
    bit          pre, pn;
    int          gap;
    rst = 1'b1; cmd = 16'h0000; cmd_rdy = 1'b0;
    cal_done = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    m_hdng = 12'h000; m_resp = 8'h00; m_aff = 1'b0;
    step(); step();
    check_reset_vals("reset");
    rst = 1'b0;
    step();

    run_cmd(16'h23FF, 99, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    run_cmd(16'h4002, 5, 1'b0, 1'b0, 1'b1, 16'h2123);
    run_cmd(16'h2123, 2, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    run_cmd(16'hE000, 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    run_cmd(16'h6001, 4, 1'b0, 1'b1, 1'b0, 16'h0000);
    check_val("solve_aff_hold", lft_aff, 1);
    step();

    pre   = 1'b0;
    cur_w = 16'($urandom);
    for (int k = 0; k < 60; k++) begin
      nxt_w = 16'($urandom);
      pn    = 1'($urandom_range(0, 1));
      run_cmd(cur_w, int'($urandom_range(0, 6)), pre, 1'b1, pn, nxt_w);
      pre   = pn;
      cur_w = pn ? nxt_w : 16'($urandom);
      if (!pn) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          step();
          check_val("idle_quiet", {send_resp, clr_cmd_rdy}, 0);
          check_val("idle_resp", resp, m_resp);
        end
      end
    end
    if (pre) begin
      run_cmd(cur_w, 1, 1'b1, 1'b0, 1'b0, 16'h0000);
    end
    step();

    reset_mid(16'h6000);
    reset_mid(16'h4003);
    reset_mid(16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
